// File: rtl/clock_hms_pkg.sv
// Shared types and limits for the hh:mm:ss time-of-day stage.
package clock_hms_pkg;

    localparam int unsigned BCD2_W = 8;
    localparam int unsigned MS_W   = 12;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SET_H = 2'b01,
        ST_SET_M = 2'b10
    } set_state_e;

    localparam logic [BCD2_W-1:0] SEC_MAX = 8'h59;
    localparam logic [BCD2_W-1:0] MIN_MAX = 8'h59;
    localparam logic [BCD2_W-1:0] HR_MAX  = 8'h23;

    // Two-digit BCD increment; wraps to 00 after max, each digit wraps 9 -> 0.
    function automatic logic [BCD2_W-1:0] bcd2_inc(input logic [BCD2_W-1:0] v,
                                                   input logic [BCD2_W-1:0] max);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[3:0];
        hi = v[7:4];
        if (v == max) begin
            lo = 4'd0;
            hi = 4'd0;
        end else if (lo >= 4'd9) begin
            lo = 4'd0;
            hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/clock_hms_bcd2_counter.sv
// Two-digit BCD counter with clear, load and a carry pulse on wrap from MAX.
module bcd2_counter
    import clock_hms_pkg::*;
#(
    parameter logic [BCD2_W-1:0] MAX     = 8'h59,
    parameter logic [BCD2_W-1:0] RST_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    input  logic              load,
    input  logic [BCD2_W-1:0] load_value,
    output logic [BCD2_W-1:0] value,
    output logic              carry_c
);

    // Carry reflects the increment even when clr wins, so a wrap still ripples upward.
    assign carry_c = inc && (value == MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= RST_VAL;
        end else if (clr) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= bcd2_inc(value, MAX);
        end
    end

endmodule

// File: rtl/clock_hms.sv
// 24-hour BCD time-of-day keeper with a two-button hour/minute setting FSM.
module clock_hms
    import clock_hms_pkg::*;
#(
    parameter logic [BCD2_W-1:0] INIT_HH = 8'h12,
    parameter logic [BCD2_W-1:0] INIT_MM = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sec_tick,
    input  logic [MS_W-1:0]   ms_bcd,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [BCD2_W-1:0] hh_bcd,
    output logic [BCD2_W-1:0] mm_bcd,
    output logic [BCD2_W-1:0] ss_bcd,
    output logic [1:0]        set_state,
    output logic              blank,
    output logic              day_tick
);

    set_state_e state_q;
    set_state_e state_d;

    logic mode_prev;
    logic inc_prev;
    logic mode_ev_c;
    logic inc_ev_c;

    logic run_c;
    logic ss_clr_c;
    logic hh_edit_c;
    logic mm_edit_c;

    logic ss_inc_c;
    logic mm_inc_c;
    logic hh_inc_c;
    logic ss_carry_c;
    logic mm_carry_c;
    logic hh_carry_c;

    logic unused_ms_low;
    assign unused_ms_low = ^ms_bcd[7:0];

    // Prev registers reset high so a button held through reset never fires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_prev <= 1'b1;
            inc_prev  <= 1'b1;
        end else begin
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
        end
    end

    assign mode_ev_c = btn_mode & ~mode_prev;
    assign inc_ev_c  = btn_inc  & ~inc_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state enables; a mode event always swallows a coincident inc.
    always_comb begin
        state_d   = state_q;
        run_c     = 1'b0;
        ss_clr_c  = 1'b0;
        hh_edit_c = 1'b0;
        mm_edit_c = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                run_c = 1'b1;
                if (mode_ev_c) begin
                    state_d  = ST_SET_H;
                    ss_clr_c = 1'b1;
                end
            end
            ST_SET_H: begin
                ss_clr_c = 1'b1;
                if (mode_ev_c) begin
                    state_d = ST_SET_M;
                end else begin
                    hh_edit_c = inc_ev_c;
                end
            end
            ST_SET_M: begin
                ss_clr_c = 1'b1;
                if (mode_ev_c) begin
                    state_d = ST_RUN;
                end else begin
                    mm_edit_c = inc_ev_c;
                end
            end
            default: begin
                state_d  = ST_RUN;
                ss_clr_c = 1'b1;
            end
        endcase
    end

    // Carries only ripple while running; edits never carry upward.
    assign ss_inc_c = run_c & sec_tick;
    assign mm_inc_c = (run_c & ss_carry_c) | mm_edit_c;
    assign hh_inc_c = (run_c & mm_carry_c) | hh_edit_c;

    bcd2_counter #(
        .MAX     (SEC_MAX),
        .RST_VAL (8'h00)
    ) u_ss (
        .clk        (clk),
        .reset      (reset),
        .inc        (ss_inc_c),
        .clr        (ss_clr_c),
        .load       (1'b0),
        .load_value (8'h00),
        .value      (ss_bcd),
        .carry_c    (ss_carry_c)
    );

    bcd2_counter #(
        .MAX     (MIN_MAX),
        .RST_VAL (INIT_MM)
    ) u_mm (
        .clk        (clk),
        .reset      (reset),
        .inc        (mm_inc_c),
        .clr        (1'b0),
        .load       (1'b0),
        .load_value (8'h00),
        .value      (mm_bcd),
        .carry_c    (mm_carry_c)
    );

    bcd2_counter #(
        .MAX     (HR_MAX),
        .RST_VAL (INIT_HH)
    ) u_hh (
        .clk        (clk),
        .reset      (reset),
        .inc        (hh_inc_c),
        .clr        (1'b0),
        .load       (1'b0),
        .load_value (8'h00),
        .value      (hh_bcd),
        .carry_c    (hh_carry_c)
    );

    assign set_state = state_q;

    // Blink the edited field during the upper half of each second.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blank    <= 1'b0;
            day_tick <= 1'b0;
        end else begin
            blank    <= (state_q != ST_RUN) && (ms_bcd[11:8] >= 4'd5);
            day_tick <= run_c & hh_carry_c;
        end
    end

endmodule

// File: tb/tb_clock_hms.sv
// Directed bench for clock_hms: rollover, carries, setting FSM, blank and reset.
module tb_clock_hms;

    logic        clk = 1'b0;
    logic        reset;
    logic        sec_tick;
    logic [11:0] ms_bcd;
    logic        btn_mode;
    logic        btn_inc;
    logic [7:0]  hh_bcd;
    logic [7:0]  mm_bcd;
    logic [7:0]  ss_bcd;
    logic [1:0]  set_state;
    logic        blank;
    logic        day_tick;

    int n_checks = 0;
    int n_fail   = 0;

    clock_hms #(
        .INIT_HH (8'h23),
        .INIT_MM (8'h59)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sec_tick  (sec_tick),
        .ms_bcd    (ms_bcd),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hh_bcd    (hh_bcd),
        .mm_bcd    (mm_bcd),
        .ss_bcd    (ss_bcd),
        .set_state (set_state),
        .blank     (blank),
        .day_tick  (day_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input logic [7:0] hh, input logic [7:0] mm,
                              input logic [7:0] ss);
        check({tag, ".hh"}, hh_bcd, hh);
        check({tag, ".mm"}, mm_bcd, mm);
        check({tag, ".ss"}, ss_bcd, ss);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1'b1;
            step();
        end
        sec_tick = 1'b0;
    endtask

    task automatic mode_pulse();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
    endtask

    task automatic inc_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1;
            step();
            btn_inc = 1'b0;
            step();
        end
    endtask

    initial begin
        reset    = 1'b0;
        sec_tick = 1'b0;
        ms_bcd   = 12'h000;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();
        step();
        check_time("reset", 8'h23, 8'h59, 8'h00);
        check("reset.state", 8'(set_state), 8'h00);
        check("reset.blank", 8'(blank), 8'h00);
        check("reset.day_tick", 8'(day_tick), 8'h00);
        reset = 1'b1;
        step();

        // Count up to 23:59:59, checking the first tick and the units-digit wrap.
        ticks(1);
        check("run.ss01", ss_bcd, 8'h01);
        ticks(9);
        check("run.ss10", ss_bcd, 8'h10);
        ticks(49);
        check_time("pre_roll", 8'h23, 8'h59, 8'h59);
        check("pre_roll.day_tick", 8'(day_tick), 8'h00);
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        check_time("roll", 8'h00, 8'h00, 8'h00);
        check("roll.day_tick", 8'(day_tick), 8'h01);
        step();
        check("roll.day_tick_drop", 8'(day_tick), 8'h00);

        // Minute carry from 00:00:58.
        ticks(58);
        check("m58.ss", ss_bcd, 8'h58);
        ticks(1);
        check_time("m59", 8'h00, 8'h00, 8'h59);
        ticks(1);
        check_time("mcarry", 8'h00, 8'h01, 8'h00);
        check("mcarry.day_tick", 8'(day_tick), 8'h00);

        // Mode event coincident with a carrying tick: carry lands, ss cleared.
        ticks(59);
        check_time("m1_59", 8'h00, 8'h01, 8'h59);
        btn_mode = 1'b1;
        sec_tick = 1'b1;
        step();
        btn_mode = 1'b0;
        sec_tick = 1'b0;
        check("modetick.state", 8'(set_state), 8'h01);
        check_time("modetick", 8'h00, 8'h02, 8'h00);
        step();

        // SET_H: ticks ignored, hours wrap without carry.
        ticks(1);
        check("seth.ss_hold", ss_bcd, 8'h00);
        inc_pulses(12);
        check("seth.hh12", hh_bcd, 8'h12);
        inc_pulses(12);
        check_time("seth.wrap", 8'h00, 8'h02, 8'h00);
        check("seth.state", 8'(set_state), 8'h01);

        // SET_M: minutes wrap without touching hours.
        mode_pulse();
        check("setm.state", 8'(set_state), 8'h02);
        inc_pulses(57);
        check("setm.mm59", mm_bcd, 8'h59);
        inc_pulses(1);
        check_time("setm.wrap", 8'h00, 8'h00, 8'h00);
        inc_pulses(59);
        check("setm.mm59b", mm_bcd, 8'h59);
        ticks(1);
        check("setm.ss_hold", ss_bcd, 8'h00);

        // Blank follows the ms hundreds digit with one cycle of latency.
        ms_bcd = 12'h499;
        step();
        check("blank.499", 8'(blank), 8'h00);
        ms_bcd = 12'h500;
        check("blank.pre500", 8'(blank), 8'h00);
        step();
        check("blank.500", 8'(blank), 8'h01);

        // Mode and inc together: mode wins, minute untouched.
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        check("modeinc.state", 8'(set_state), 8'h00);
        check("modeinc.mm", mm_bcd, 8'h59);
        ms_bcd = 12'h700;
        step();
        check("blank.run700", 8'(blank), 8'h00);
        ticks(1);
        check_time("resume", 8'h00, 8'h59, 8'h01);

        // Reset mid-edit discards the edit; held buttons do not fire afterwards.
        mode_pulse();
        check("edit.state", 8'(set_state), 8'h01);
        check("edit.ss", ss_bcd, 8'h00);
        inc_pulses(3);
        check("edit.hh03", hh_bcd, 8'h03);
        ms_bcd   = 12'h800;
        step();
        check("edit.blank", 8'(blank), 8'h01);
        reset    = 1'b0;
        btn_inc  = 1'b1;
        btn_mode = 1'b1;
        step();
        check_time("midreset", 8'h23, 8'h59, 8'h00);
        check("midreset.state", 8'(set_state), 8'h00);
        check("midreset.blank", 8'(blank), 8'h00);
        reset = 1'b1;
        step();
        step();
        check("held.state", 8'(set_state), 8'h00);
        check_time("held", 8'h23, 8'h59, 8'h00);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_hms.md
# clock_hms

Time-of-day stage directly downstream of the 1 ms BCD counter. It consumes that stage's one-cycle seconds pulse and its BCD millisecond value, and keeps a 24-hour BCD clock, hh:mm:ss. A two-button setting FSM adjusts hours and minutes. The block drives the display stage with BCD digits and a blink-blank flag during setting.

## Interface
Parameters:
- INIT_HH, 8'h12: BCD hour loaded at reset. Legal range 00–23.
- INIT_MM, 8'h00: BCD minute loaded at reset. Legal range 00–59.

Ports:
- clk  in  1  same 1 kHz clock as the ms counter.
- reset  in  1  synchronous, active-low.
- sec_tick  in  1  one-cycle pulse from the ms counter when 999 wraps to 000.
- ms_bcd  in  12  BCD milliseconds 000–999; only [11:8], the hundreds digit, is used.
- btn_mode  in  1  level, already synchronised and debounced.
- btn_inc  in  1  level, already synchronised and debounced.
- hh_bcd  out  8  BCD hours 00–23.
- mm_bcd  out  8  BCD minutes 00–59.
- ss_bcd  out  8  BCD seconds 00–59.
- set_state  out  2  00 = RUN, 01 = SET_H, 10 = SET_M.
- blank  out  1  blank the field being edited.
- day_tick  out  1  one-cycle pulse on 23:59:59 → 00:00:00.

## Operation
- Edge detection:
  - Each button has a previous-value register that resets to 1, so a button held through reset does not fire.
  - An event is `btn & ~prev`.
- FSM (the state is `set_state`):
  - RUN → SET_H on a mode event.
  - SET_H → SET_M on a mode event.
  - SET_M → RUN on a mode event.
- RUN behaviour:
  - Each sec_tick increments ss.
  - 59 → 00 carries into mm; mm 59 → 00 carries into hh; hh 23 → 00 wraps.
  - All carries resolve in the same edge. Full rollover 23:59:59 → 00:00:00 asserts day_tick for exactly that one cycle.
  - Inc events are ignored.
- Entering SET_H clears ss to 00.
- In SET_H and SET_M, sec_tick is ignored and ss is held at 00.
- SET_H: an inc event gives hh+1, 23 → 00. No carry out.
- SET_M: an inc event gives mm+1, 59 → 00. No carry into hh.
- SET_M → RUN: counting resumes from ss = 00 at the next sec_tick.
- Simultaneous mode and inc events: mode wins and inc is discarded.
- Simultaneous mode event and sec_tick in RUN: the tick is applied and the state advances to SET_H. The clearing of ss on entry to SET_H takes precedence, so ss = 00.
- blank is registered: `blank <= (set_state != RUN) && (ms_bcd[11:8] >= 5)`. This blinks at 1 Hz with 50 % duty.
- BCD rule: a digit never holds a value of A–F. Each digit increments and wraps independently.

## Timing
- Reset values:
  - hh = INIT_HH, mm = INIT_MM, ss = 00.
  - set_state = RUN.
  - day_tick = 0, blank = 0.
  - Button prev registers = 1.
- Latency:
  - sec_tick at edge N: the new ss/mm/hh are visible after edge N+1.
  - A button rising at edge N is registered at edge N. The state or field change is visible after edge N+1.
- blank has one cycle of latency from ms_bcd.
- day_tick is asserted in the same cycle the outputs show 00:00:00.
- Reset asserted in any state, including mid-SET: the block returns to reset values on the next edge and the edit in progress is discarded.

## Structure
- Package `clock_hms_pkg`:
  - State encoding: ST_RUN, ST_SET_H, ST_SET_M.
  - BCD limits: SEC_MAX = 8'h59, MIN_MAX = 8'h59, HR_MAX = 8'h23.
- Sub-module `bcd2_counter`:
  - Two-digit BCD counter.
  - Parameter MAX.
  - Inputs: inc, clr, load value.
  - Outputs: value, carry pulse.
  - Instantiated three times.
- Top level holds the FSM, the edge detectors, blank and day_tick.

## Test plan
- INIT 23:59, apply 59 sec_ticks then one more → 23:59:59, then 00:00:00 with day_tick high for exactly one cycle.
- From 00:00:58, two sec_ticks → 00:00:59, then 00:01:00. day_tick stays 0.
- One mode event → SET_H with ss = 00. Inc ×12 from hh = 12 → hh = 00. A sec_tick during SET_H leaves ss at 00.
- In SET_M with mm = 59, raise mode and inc in the same cycle → set_state = RUN and mm stays 59.
- In SET_M, ms_bcd = 12'h499 → blank = 0. ms_bcd = 12'h500 → blank = 1 one cycle later. In RUN with 12'h700 → blank = 0.
- Reset low mid-SET_H with hh edited to 03 → after one edge, outputs show INIT_HH:INIT_MM:00 and RUN. With btn_inc held high through reset, no inc event occurs.
